// File: rtl/riscv_v_rf_wb_ctrl.sv
// rtl/riscv_v_rf_wb_ctrl.sv - vector RF write-side controller: two-producer arbiter, byte-enable generation, writeback FIFO
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_ready, alu_*      ALU writeback channel (addr, data, sew, vl, vm)
//   ld_valid/ld_ready,   ld_*       load-unit writeback channel (same fields)
//   mask_in                         v0 mask bits, one per element
//   wb_hold                         freezes the FIFO pop
//   rf_wr_addr/rf_data_in/rf_wr_en  RF write port (byte enables)
//   wb_done                         a write is presented this cycle
//   wb_busy                         FIFO non-empty
module riscv_v_rf_wb_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4,
    localparam int NB  = DATA_WIDTH / 8,
    localparam int VLW = $clog2(NB) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [1:0]            alu_sew,
    input  logic [VLW-1:0]        alu_vl,
    input  logic                  alu_vm,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic [1:0]            ld_sew,
    input  logic [VLW-1:0]        ld_vl,
    input  logic                  ld_vm,
    input  logic [NB-1:0]         mask_in,
    input  logic                  wb_hold,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_data_in,
    output logic [NB-1:0]         rf_wr_en,
    output logic                  wb_done,
    output logic                  wb_busy
);

    localparam int IW = $clog2(NB);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Byte b belongs to element b>>sew; element is live if below the clipped vl
    // and either unmasked or its v0 bit is set.
    function automatic logic [NB-1:0] calc_en(input logic [1:0]     sew,
                                              input logic [VLW-1:0] vl,
                                              input logic           vm,
                                              input logic [NB-1:0]  mask);
        logic [VLW-1:0] vlmax;
        logic [VLW-1:0] vl_eff;
        logic [IW-1:0]  e_idx;
        logic [NB-1:0]  en;
        vlmax  = VLW'(NB >> sew);
        vl_eff = (vl > vlmax) ? vlmax : vl;
        en     = '0;
        for (int b = 0; b < NB; b++) begin
            e_idx = IW'(b >> sew);
            en[b] = ({1'b0, e_idx} < vl_eff) && (vm || mask[e_idx]);
        end
        return en;
    endfunction

    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [NB-1:0]         mem_en   [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr, rd_next, idx;
    logic [CW-1:0] count, cnt_next, cnt_after_pop;
    logic          rr_ld;
    logic [NB-1:0] head_en;

    logic                  grant_alu, grant_ld, sel_vm, space, accept_ok;
    logic                  accept, push, pop, v0_pending;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NB-1:0]         push_en;

    // Any buffered write to v0 would make mask_in stale for a masked op.
    always_comb begin
        v0_pending = 1'b0;
        idx        = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (mem_addr[idx] == '0))
                v0_pending = 1'b1;
        end
    end

    always_comb begin
        pop       = (count != '0) && !wb_hold;
        grant_ld  = ld_valid && (!alu_valid || rr_ld);
        grant_alu = alu_valid && !grant_ld;
        sel_vm    = grant_ld ? ld_vm   : alu_vm;
        sel_addr  = grant_ld ? ld_addr : alu_addr;
        sel_data  = grant_ld ? ld_data : alu_data;
        push_en   = grant_ld ? calc_en(ld_sew, ld_vl, ld_vm, mask_in)
                             : calc_en(alu_sew, alu_vl, alu_vm, mask_in);
        space     = (count != CW'(FIFO_DEPTH)) || pop;
        accept_ok = space && !(v0_pending && !sel_vm);
        alu_ready = grant_alu && accept_ok;
        ld_ready  = grant_ld && accept_ok;
        accept    = alu_ready || ld_ready;
        // Fully disabled results finish the handshake but never occupy a slot.
        push      = accept && (push_en != '0);

        rd_next       = pop ? rd_ptr + PW'(1) : rd_ptr;
        cnt_after_pop = count - CW'(pop);
        cnt_next      = cnt_after_pop + CW'(push);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= sel_addr;
            mem_data[wr_ptr] <= sel_data;
            mem_en[wr_ptr]   <= push_en;
        end
    end

    // Head registers hold the entry presented next cycle; when the FIFO drains
    // they keep the last address/data so the RF port stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rr_ld      <= 1'b0;
            rf_wr_addr <= '0;
            rf_data_in <= '0;
            head_en    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_next;
            count  <= cnt_next;
            if (alu_valid && ld_valid && accept)
                rr_ld <= !rr_ld;
            if (cnt_next != '0) begin
                if (cnt_after_pop == '0) begin
                    rf_wr_addr <= sel_addr;
                    rf_data_in <= sel_data;
                    head_en    <= push_en;
                end else begin
                    rf_wr_addr <= mem_addr[rd_next];
                    rf_data_in <= mem_data[rd_next];
                    head_en    <= mem_en[rd_next];
                end
            end
        end
    end

    assign wb_busy  = (count != '0);
    assign wb_done  = pop;
    assign rf_wr_en = pop ? head_en : '0;

endmodule

// File: tb/tb_riscv_v_rf_wb_ctrl.sv
// tb/tb_riscv_v_rf_wb_ctrl.sv - directed self-checking bench for riscv_v_rf_wb_ctrl
module tb_riscv_v_rf_wb_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alu_valid, alu_ready, alu_vm;
    logic [4:0]   alu_addr;
    logic [127:0] alu_data;
    logic [1:0]   alu_sew;
    logic [4:0]   alu_vl;
    logic         ld_valid, ld_ready, ld_vm;
    logic [4:0]   ld_addr;
    logic [127:0] ld_data;
    logic [1:0]   ld_sew;
    logic [4:0]   ld_vl;
    logic [15:0]  mask_in;
    logic         wb_hold;
    logic [4:0]   rf_wr_addr;
    logic [127:0] rf_data_in;
    logic [15:0]  rf_wr_en;
    logic         wb_done, wb_busy;

    int checks   = 0;
    int failures = 0;

    riscv_v_rf_wb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_data(alu_data), .alu_sew(alu_sew), .alu_vl(alu_vl), .alu_vm(alu_vm),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_sew(ld_sew), .ld_vl(ld_vl), .ld_vm(ld_vm),
        .mask_in(mask_in), .wb_hold(wb_hold),
        .rf_wr_addr(rf_wr_addr), .rf_data_in(rf_data_in), .rf_wr_en(rf_wr_en),
        .wb_done(wb_done), .wb_busy(wb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [4:0] a, input logic [127:0] d, input logic [1:0] s,
                           input logic [4:0] vl, input logic vm);
        alu_valid = 1'b1; alu_addr = a; alu_data = d; alu_sew = s; alu_vl = vl; alu_vm = vm;
    endtask

    // One isolated ALU op into an empty FIFO, checked on the following cycle.
    task automatic one_alu(input string tag, input logic [4:0] a, input logic [1:0] s,
                           input logic [4:0] vl, input logic vm, input logic [15:0] m,
                           input logic [15:0] exp_en);
        set_alu(a, {8{a, 11'h5A5}}, s, vl, vm);
        mask_in = m;
        #1;
        chk({tag, "_ready"}, alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        chk({tag, "_en"}, rf_wr_en, exp_en);
        chk({tag, "_done"}, wb_done, exp_en != 16'h0);
        if (exp_en != 16'h0) chk({tag, "_addr"}, rf_wr_addr, a);
        tick();
        chk({tag, "_drain"}, wb_busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0; wb_hold = 1'b0;
        alu_addr = '0; alu_data = '0; alu_sew = '0; alu_vl = '0; alu_vm = 1'b1;
        ld_addr = '0; ld_data = '0; ld_sew = '0; ld_vl = '0; ld_vm = 1'b1;
        mask_in = '0;
        #12;
        chk("rst_wr_en", rf_wr_en, 16'h0);
        chk("rst_addr", rf_wr_addr, 5'd0);
        chk("rst_data", rf_data_in, 128'h0);
        chk("rst_busy", wb_busy, 1'b0);
        chk("rst_done", wb_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic e8 full write with data and hold-last-value checks.
        set_alu(5'd3, 128'h0F0E0D0C0B0A09080706050403020100, 2'd0, 5'd16, 1'b1);
        #1;
        chk("t1_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        chk("t1_addr", rf_wr_addr, 5'd3);
        chk("t1_en", rf_wr_en, 16'hFFFF);
        chk("t1_done", wb_done, 1'b1);
        chk("t1_data", rf_data_in, 128'h0F0E0D0C0B0A09080706050403020100);
        tick();
        chk("t1_idle_en", rf_wr_en, 16'h0);
        chk("t1_idle_done", wb_done, 1'b0);
        chk("t1_hold_addr", rf_wr_addr, 5'd3);

        one_alu("t2_e32_vl3", 5'd4, 2'd2, 5'd3, 1'b1, 16'h0, 16'h0FFF);
        one_alu("t2_e32_vl9", 5'd5, 2'd2, 5'd9, 1'b1, 16'h0, 16'hFFFF);
        one_alu("t2_e64_vl1", 5'd9, 2'd3, 5'd1, 1'b1, 16'h0, 16'h00FF);
        one_alu("t3_mask_a5", 5'd6, 2'd1, 5'd8, 1'b0, 16'h00A5, 16'hCC33);
        one_alu("t3_mask_0", 5'd7, 2'd1, 5'd8, 1'b0, 16'h0000, 16'h0000);
        one_alu("t3_vl0", 5'd8, 2'd0, 5'd0, 1'b1, 16'h0, 16'h0000);

        // Contended arbitration: both valid for 6 cycles, ALU first.
        set_alu(5'd10, 128'h0, 2'd0, 5'd16, 1'b1);
        ld_valid = 1'b1; ld_addr = 5'd20; ld_sew = 2'd0; ld_vl = 5'd16; ld_vm = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alu_data = 128'(i);
            ld_data  = 128'(i + 100);
            #1;
            chk("t4_alu_ready", alu_ready, (i % 2) == 0);
            chk("t4_ld_ready", ld_ready, (i % 2) == 1);
            tick();
            chk("t4_addr", rf_wr_addr, ((i % 2) == 0) ? 5'd10 : 5'd20);
            chk("t4_data", rf_data_in, ((i % 2) == 0) ? 128'(i) : 128'(i + 100));
            chk("t4_en", rf_wr_en, 16'hFFFF);
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        tick();
        chk("t4_drain", wb_busy, 1'b0);

        // Hold: four fill the FIFO, fifth waits, then five back-to-back writes.
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_alu(5'(i + 1), 128'(i + 1), 2'd0, 5'd16, 1'b1);
            #1;
            chk("t5_fill_ready", alu_ready, 1'b1);
            tick();
            chk("t5_hold_en", rf_wr_en, 16'h0);
        end
        set_alu(5'd5, 128'd5, 2'd0, 5'd16, 1'b1);
        #1;
        chk("t5_full_ready", alu_ready, 1'b0);
        chk("t5_full_busy", wb_busy, 1'b1);
        tick();
        chk("t5_full_ready2", alu_ready, 1'b0);
        wb_hold = 1'b0;
        #1;
        chk("t5_pop_ready", alu_ready, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("t5_wr_addr", rf_wr_addr, 5'(k + 1));
            chk("t5_wr_en", rf_wr_en, 16'hFFFF);
            tick();
            if (k == 0) alu_valid = 1'b0;
        end
        chk("t5_drain", wb_busy, 1'b0);

        // v0 hazard: masked op waits until the v0 write has been presented.
        wb_hold = 1'b1;
        set_alu(5'd0, 128'hAA, 2'd0, 5'd16, 1'b1);
        tick();
        set_alu(5'd8, 128'hBB, 2'd0, 5'd16, 1'b0);
        mask_in = 16'hFFFF;
        #1;
        chk("t6_haz_ready", alu_ready, 1'b0);
        tick();
        chk("t6_haz_ready2", alu_ready, 1'b0);
        wb_hold = 1'b0;
        #1;
        chk("t6_v0_present", rf_wr_addr, 5'd0);
        chk("t6_v0_en", rf_wr_en, 16'hFFFF);
        chk("t6_haz_ready3", alu_ready, 1'b0);
        tick();
        chk("t6_clear_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        chk("t6_masked_addr", rf_wr_addr, 5'd8);
        chk("t6_masked_en", rf_wr_en, 16'hFFFF);
        tick();

        // Reset in the middle of a burst drops buffered entries at once.
        wb_hold = 1'b1;
        set_alu(5'd11, 128'h11, 2'd0, 5'd16, 1'b1);
        tick();
        set_alu(5'd12, 128'h12, 2'd0, 5'd16, 1'b1);
        tick();
        alu_valid = 1'b0;
        wb_hold = 1'b0;
        #1;
        chk("t6_burst_en", rf_wr_en, 16'hFFFF);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en", rf_wr_en, 16'h0);
        chk("t6_rst_busy", wb_busy, 1'b0);
        chk("t6_rst_done", wb_done, 1'b0);
        #10;
        rst_n = 1'b1;
        tick();
        chk("t6_post_rst_en", rf_wr_en, 16'h0);
        chk("t6_post_rst_busy", wb_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
